// File: rtl/debug_uart_tx.sv
// Debug UART transmitter: sends OP_OK (0x02), or OP_SIGNAL (0x01 + pc + signals) when DEBUG_TX_SIGNAL_EN is defined.
// Line goes low on the accepting edge; bytes are back to back; requests that arrive while busy are dropped.
module debug_uart_tx #(
    parameter int BAUD_DIV = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_ok,
    input  logic        send_signal,
    input  logic [31:0] pc,
    input  logic [15:0] signals,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int              CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD_DIV - 1);
    localparam logic [7:0]      OP_OK     = 8'h02;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic [31:0]      pc_q, pc_d;
    logic [15:0]      sig_q, sig_d;
    logic             is_sig_q, is_sig_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             req_sig;
    logic [31:0]      lat_pc;
    logic [15:0]      lat_sig;
    logic [2:0]       last_byte;
    logic [7:0]       cur_byte;

`ifdef DEBUG_TX_SIGNAL_EN
    assign req_sig   = send_signal;
    assign lat_pc    = pc;
    assign lat_sig   = signals;
    assign last_byte = is_sig_q ? 3'd6 : 3'd0;

    always_comb begin
        cur_byte = OP_OK;
        case (byte_q)
            3'd0:    cur_byte = is_sig_q ? 8'h01 : OP_OK;
            3'd1:    cur_byte = pc_q[7:0];
            3'd2:    cur_byte = pc_q[15:8];
            3'd3:    cur_byte = pc_q[23:16];
            3'd4:    cur_byte = pc_q[31:24];
            3'd5:    cur_byte = sig_q[7:0];
            3'd6:    cur_byte = sig_q[15:8];
            default: cur_byte = OP_OK;
        endcase
    end
`else
    // OP_SIGNAL inputs stay on the port list but feed nothing in this build.
    assign req_sig   = 1'b0;
    assign lat_pc    = '0;
    assign lat_sig   = '0;
    assign last_byte = 3'd0;
    assign cur_byte  = OP_OK;

    logic unused_inputs;
    assign unused_inputs = ^{send_signal, pc, signals, pc_q, sig_q, is_sig_q};
`endif

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        pc_d     = pc_q;
        sig_d    = sig_q;
        is_sig_d = is_sig_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (send_ok || req_sig) begin
                    // Start bit is driven from this very edge, so START lasts BAUD_DIV cycles.
                    state_d  = START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    cyc_d    = '0;
                    bit_d    = 3'd0;
                    byte_d   = 3'd0;
                    is_sig_d = req_sig;
                    pc_d     = lat_pc;
                    sig_d    = lat_sig;
                end
            end
            START: begin
                if (cyc_q == CNT_MAX) begin
                    cyc_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cyc_q == CNT_MAX) begin
                    cyc_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cyc_q == CNT_MAX) begin
                    cyc_d = '0;
                    if (byte_q == last_byte) begin
                        byte_d  = 3'd0;
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 3'd0;
            pc_q     <= '0;
            sig_q    <= '0;
            is_sig_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            pc_q     <= pc_d;
            sig_q    <= sig_d;
            is_sig_q <= is_sig_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx with a short bit period; frames are checked cycle by cycle.
module tb_debug_uart_tx;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        send_ok = 1'b0;
    logic        send_signal = 1'b0;
    logic [31:0] pc = '0;
    logic [15:0] signals = '0;
    logic        uart_tx, busy, done;

    int total = 0;
    int bad   = 0;

    debug_uart_tx #(.BAUD_DIV(BD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .send_ok     (send_ok),
        .send_signal (send_signal),
        .pc          (pc),
        .signals     (signals),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at cycle 0 of a start bit; ends at cycle 0 after the stop bit.
    task automatic check_byte(input string tag, input logic [7:0] b, input bit poke);
        int         errs = 0;
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int c = 0; c < 10 * BD; c++) begin
            if (uart_tx !== fr[c / BD] || busy !== 1'b1 || done !== 1'b0) errs++;
            if (poke && c == 3 * BD) begin
                send_ok     = 1'b1;
                send_signal = 1'b1;
                pc          = 32'hFFFF_FFFF;
            end
            if (poke && c == 3 * BD + 1) begin
                send_ok     = 1'b0;
                send_signal = 1'b0;
            end
            tick();
        end
        chk(tag, errs, 0);
    endtask

    task automatic end_chk(input string tag);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_line"}, {31'd0, uart_tx}, 32'd1);
    endtask

    task automatic idle_chk(input string tag, input int n);
        int errs = 0;
        for (int c = 0; c < n; c++) begin
            if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
            tick();
        end
        chk(tag, errs, 0);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_line", {31'd0, uart_tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_chk("idle_after_rst", 2 * BD);

        // OP_OK single pulse, with a dropped request mid-packet
        send_ok = 1'b1;
        tick();
        send_ok = 1'b0;
        check_byte("ok_byte", 8'h02, 1'b1);
        end_chk("ok_end");
        tick();
        idle_chk("ok_no_extra", 12 * BD);

        // Back-to-back with send_ok held high: one idle cycle between frames
        send_ok = 1'b1;
        tick();
        check_byte("b2b_byte0", 8'h02, 1'b0);
        end_chk("b2b_end0");
        tick();
        chk("b2b_restart_line", {31'd0, uart_tx}, 32'd0);
        chk("b2b_restart_busy", {31'd0, busy}, 32'd1);
        send_ok = 1'b0;
        check_byte("b2b_byte1", 8'h02, 1'b0);
        end_chk("b2b_end1");
        tick();
        idle_chk("b2b_idle", 2 * BD);

        // Reset mid-frame
        send_ok = 1'b1;
        tick();
        send_ok = 1'b0;
        repeat (3 * BD + 5) tick();
        chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_line", {31'd0, uart_tx}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_chk("midrst_quiet", 12 * BD);

`ifdef DEBUG_TX_SIGNAL_EN
        // OP_SIGNAL wins the collision; pc altered mid-packet
        pc          = 32'h0000_00DC;
        signals     = 16'hA55A;
        send_ok     = 1'b1;
        send_signal = 1'b1;
        tick();
        send_ok     = 1'b0;
        send_signal = 1'b0;
        check_byte("sig_b0", 8'h01, 1'b0);
        check_byte("sig_b1", 8'hDC, 1'b0);
        check_byte("sig_b2", 8'h00, 1'b1);
        check_byte("sig_b3", 8'h00, 1'b0);
        check_byte("sig_b4", 8'h00, 1'b0);
        check_byte("sig_b5", 8'h5A, 1'b0);
        check_byte("sig_b6", 8'hA5, 1'b0);
        end_chk("sig_end");
        tick();
        idle_chk("sig_no_extra", 12 * BD);
`else
        // send_signal ignored; send_ok still yields 0x02
        pc          = 32'h0000_00DC;
        signals     = 16'hA55A;
        send_signal = 1'b1;
        idle_chk("nosig_quiet", 20 * BD);
        send_ok = 1'b1;
        tick();
        send_ok = 1'b0;
        check_byte("nosig_ok_byte", 8'h02, 1'b0);
        end_chk("nosig_ok_end");
        send_signal = 1'b0;
        tick();
        idle_chk("nosig_idle", 2 * BD);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
